// File: rtl/bdp_pkg.sv
// Shared width derivations and accumulator limit helpers for the bit-serial
// dot-product accumulator.
package bdp_pkg;

   // Lane product width: one extra bit so that negating the most negative
   // activation is exact.
   function automatic int prod_w(input int act_w);
      return act_w + 1;
   endfunction

   // Reduced sum width: the adder tree grows one bit per level.
   function automatic int sum_w(input int act_w, input int lanes);
      return act_w + 1 + $clog2(lanes);
   endfunction

   // Largest bit-plane shift.
   function automatic int shift_max(input int shift_w);
      return (1 << shift_w) - 1;
   endfunction

   // Most positive value of an acc_w-bit signed accumulator.
   function automatic longint acc_max(input int acc_w);
      return (longint'(1) <<< (acc_w - 1)) - 1;
   endfunction

   // Most negative value of an acc_w-bit signed accumulator.
   function automatic longint acc_min(input int acc_w);
      return -(longint'(1) <<< (acc_w - 1));
   endfunction

endpackage

// File: rtl/bdp_psum_tree.sv
// Combinational reduction of one bit-plane beat: per-lane conditional
// (optionally negated) activation, summed by a balanced adder tree.
module bdp_psum_tree
   import bdp_pkg::*;
#(
   parameter int LANES = 8,
   parameter int ACT_W = 8
)(
   input  logic [LANES*ACT_W-1:0]        activations,
   input  logic [LANES-1:0]              weight_column,
   input  logic [LANES-1:0]              weight_sign,
   output logic [ACT_W+$clog2(LANES):0]  psum
);

   localparam int PROD_W = prod_w(ACT_W);
   localparam int SUM_W  = sum_w(ACT_W, LANES);

   // Heap-ordered tree: leaves at LANES-1..2*LANES-2, node k sums 2k+1 and 2k+2.
   // Every node is held at the final width, which is the same as extending
   // by one bit per level since no level can overflow its own width.
   logic signed [SUM_W-1:0] node [2*LANES-1];

   // Lane products and the adder tree.
   always_comb begin
      logic signed [ACT_W-1:0]  act;
      logic signed [PROD_W-1:0] ext;
      logic signed [PROD_W-1:0] prod;
      node = '{default: '0};
      for (int i = 0; i < LANES; i++) begin
         act  = $signed(activations[i*ACT_W +: ACT_W]);
         ext  = PROD_W'(act);
         prod = '0;
         if (weight_column[i])
            prod = weight_sign[i] ? -ext : ext;
         node[LANES-1+i] = SUM_W'(prod);
      end
      for (int k = LANES - 2; k >= 0; k--)
         node[k] = node[2*k+1] + node[2*k+2];
   end

   assign psum = node[0];

endmodule

// File: rtl/bdp_accum.sv
// Bit-serial dot-product accumulator: register a beat, reduce and shift it
// by its bit-plane significance, then accumulate across a first..last frame.
// One global stall freezes the whole pipe while a result waits.
module bdp_accum
   import bdp_pkg::*;
#(
   parameter int LANES   = 8,
   parameter int ACT_W   = 8,
   parameter int SHIFT_W = 3,
   parameter int ACC_W   = 32,
   parameter bit SAT     = 1'b1
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_first,
   input  logic                     in_last,
   input  logic [LANES*ACT_W-1:0]   activations,
   input  logic [LANES-1:0]         weight_column,
   input  logic [LANES-1:0]         weight_sign,
   input  logic [SHIFT_W-1:0]       shift_offset,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ACC_W-1:0]         result,
   output logic                     overflow
);

   localparam int SUM_W     = sum_w(ACT_W, LANES);
   localparam int SHIFT_MAX = shift_max(SHIFT_W);
   // The shifted product is kept at full precision even when ACC_W is
   // undersized, so saturation sees the true value rather than a wrapped one.
   localparam int P_W       = (ACC_W > SUM_W + SHIFT_MAX) ? ACC_W : SUM_W + SHIFT_MAX;
   localparam int X_W       = P_W + 1;

   localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
   localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));
   localparam logic signed [X_W-1:0]   MAX_X   = X_W'(acc_max(ACC_W));
   localparam logic signed [X_W-1:0]   MIN_X   = X_W'(acc_min(ACC_W));

   // Returns {overflow, value}: exact add, range check against the ACC_W
   // limits, then clamp (SAT) or keep the low bits (wrap).
   function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                              input logic signed [P_W-1:0]   b);
      logic signed [X_W-1:0]   s;
      logic                    ovf;
      logic signed [ACC_W-1:0] v;
      s   = X_W'(a) + X_W'(b);
      ovf = (s > MAX_X) || (s < MIN_X);
      v   = s[ACC_W-1:0];
      if (ovf && SAT)
         v = s[X_W-1] ? ACC_MIN : ACC_MAX;
      return {ovf, v};
   endfunction

   logic                     en;
   logic                     vld_p0, first_p0, last_p0;
   logic [LANES*ACT_W-1:0]   act_p0;
   logic [LANES-1:0]         col_p0, sgn_p0;
   logic [SHIFT_W-1:0]       shift_p0;
   logic [SUM_W-1:0]         psum;
   logic signed [P_W-1:0]    shifted;
   logic                     vld_p1, first_p1, last_p1;
   logic signed [P_W-1:0]    prod_p1;
   logic signed [ACC_W-1:0]  acc, acc_base, acc_nx;
   logic                     ovf_acc, add_ovf, ovf_nx;

   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;

   bdp_psum_tree #(
      .LANES (LANES),
      .ACT_W (ACT_W)
   ) u_tree (
      .activations   (act_p0),
      .weight_column (col_p0),
      .weight_sign   (sgn_p0),
      .psum          (psum)
   );

   assign shifted = P_W'($signed(psum)) <<< shift_p0;

   assign acc_base          = first_p1 ? '0 : acc;
   assign {add_ovf, acc_nx} = sat_add(acc_base, prod_p1);
   assign ovf_nx            = add_ovf | (!first_p1 & ovf_acc);

   // S1 control: beat valid and framing flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0   <= 1'b0;
         first_p0 <= 1'b0;
         last_p0  <= 1'b0;
      end else if (en) begin
         vld_p0   <= in_valid;
         first_p0 <= in_first;
         last_p0  <= in_last;
      end
   end

   // S1 data: beat operands.
   always_ff @(posedge clk) begin
      if (en) begin
         act_p0   <= activations;
         col_p0   <= weight_column;
         sgn_p0   <= weight_sign;
         shift_p0 <= shift_offset;
      end
   end

   // S2 control: follows S1 through the reduction stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         first_p1 <= 1'b0;
         last_p1  <= 1'b0;
      end else if (en) begin
         vld_p1   <= vld_p0;
         first_p1 <= first_p0;
         last_p1  <= last_p0;
      end
   end

   // S2 data: reduced and shifted bit-plane contribution.
   always_ff @(posedge clk) begin
      if (en)
         prod_p1 <= shifted;
   end

   // S3: accumulate, publish on last, and restart from zero for the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         ovf_acc   <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else if (en) begin
         out_valid <= vld_p1 && last_p1;
         if (vld_p1) begin
            if (last_p1) begin
               result   <= acc_nx;
               overflow <= ovf_nx;
               acc      <= '0;
               ovf_acc  <= 1'b0;
            end else begin
               acc      <= acc_nx;
               ovf_acc  <= ovf_nx;
            end
         end
      end
   end

endmodule

// File: doc/bdp_accum.md
Name: bdp_accum

Overview:
- Parametrised successor to the 8-lane bit-serial dot-product unit.
- Each beat takes LANES activations and one weight bit-plane (bit + sign per lane). It forms signed products, reduces them, shifts by the bit-plane offset, and accumulates across beats framed by first/last.
- Sits between the activation buffer and the output/requant stage, with valid/ready on both sides.

Parameters:
- LANES, 8, lanes per beat (power of 2, ≥2).
- ACT_W, 8, activation width, signed two's complement.
- SHIFT_W, 3, shift_offset width; max shift 2^SHIFT_W-1.
- ACC_W, 32, accumulator/result width, signed.
- SAT, 1, 1 = saturate accumulator on overflow; 0 = wrap.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- in_first  in  1  beat starts a new dot product
- in_last  in  1  beat ends the dot product
- activations  in  LANES*ACT_W  lane i at [i*ACT_W +: ACT_W]
- weight_column  in  LANES  weight bit per lane for this plane
- weight_sign  in  LANES  1 = negate lane product
- shift_offset  in  SHIFT_W  bit-plane significance
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  ACC_W  signed dot-product result
- overflow  out  1  saturation/wrap occurred during this result's accumulation

Behaviour:
- Reset (rst_n low, async): all stage valids=0, accumulator=0, result=0, out_valid=0, overflow=0. in_ready=1 after reset. Reset mid-operation discards all in-flight beats and the partial accumulation.
- Global stall: en = !(out_valid && !out_ready); in_ready = en. When en=0, every pipeline register holds.
- S1 (input reg): on en, capture the beat fields plus v1 = in_valid. in_valid=0 inserts a bubble (v1=0).
- S2 (reduce):
  - Per lane, product = weight_bit ? (weight_sign ? -act : act) : 0, computed at ACT_W+1 bits. -2^(ACT_W-1) negates exactly, with no overflow.
  - Adder tree sign-extends one bit per level, giving sum width ACT_W+1+log2(LANES).
  - Shift left by shift_offset, sign-extended to ACC_W, registered as p2 with v2/first2/last2.
- S3 (accumulate), on en && v2:
  - acc_next = (first2 ? 0 : acc) + p2. If SAT=1 and the add overflows, clamp to ±(2^(ACC_W-1)) limits. Any overflow sets the sticky ovf.
  - If last2: result <= acc_next, overflow <= ovf_next, out_valid <= 1, acc <= 0, ovf <= 0. Otherwise acc <= acc_next.
- A beat without first after a completed result accumulates onto 0, so it behaves as first.
- first&&last in one beat is a single-beat dot product.
- Latency: last beat accepted in cycle T gives out_valid=1 in cycle T+3 (no stall). Throughput is 1 beat/cycle.
- Output handshake:
  - result and overflow stay stable while out_valid && !out_ready.
  - On out_ready, out_valid drops the next cycle unless S3 completes another last in that cycle; in that case out_valid stays 1 with the new result.
- v2=0 (bubble): acc unchanged, out_valid is not set.
- shift_offset is any value 0..2^SHIFT_W-1. The user sizes ACC_W to hold ACT_W+1+log2(LANES)+2^SHIFT_W-1 bits for lossless results.

Decomposition:
- Package bdp_pkg: derived widths PROD_W=ACT_W+1, SUM_W=PROD_W+$clog2(LANES), SHIFT_MAX; saturation-limit constant functions.
- Sub-module bdp_psum_tree: combinational per-lane sign-magnitude multiply plus sign-extending adder tree, parametrised on LANES/ACT_W.
- bdp_accum owns the S1/S2/S3 registers, stall, and accumulator.

Test Plan:
- Single beat first=last=1, LANES=8, acts 1..8, weight_column=0xFF, sign=0x00, shift=0 -> out_valid at T+3, result=36, overflow=0.
- Bit-serial 3-beat op, all acts=3; beat0 col=0xFF shift=0, beat1 col=0x00 shift=1, beat2 col=0xFF shift=2 (weight 5) -> result=120.
- Extreme negation: all acts=-128, col=0xFF, sign=0xFF, shift=7 -> result=131072 (1024<<7), no wrap.
- Backpressure: hold out_ready=0 while two more ops stream in.
  - Required: in_ready=0 after the first result; result stable.
  - Then release out_ready: both further results emerge in order, none lost or duplicated.
- Saturation, ACC_W=16, SAT=1: 4 beats, acts=127, col=0xFF, shift=7 -> result=32767, overflow=1. Next op (result 8) -> overflow=0.
- Reset mid-stream: drop rst_n after 2 of 4 beats.
  - Required: out_valid=0, result=0 immediately.
  - A fresh first..last op after release yields the correct value with no residue.
